// File: rtl/loader_pkg.sv
// Shared types and defaults for the program loader.
// The CSUM state exists only when PROGRAM_LOADER_CHECKSUM_EN is defined.
package loader_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [7:0] MAGIC_DEFAULT   = 8'hA5;
  localparam int         TIMEOUT_DEFAULT = 1250000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT_LO = 3'd1,
    ST_CNT_HI = 3'd2,
    ST_DATA   = 3'd3
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    ,
    ST_CSUM   = 3'd4
`endif
  } state_t;

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte idle counter: counts cycles while enabled and pulses expired
// for one cycle when TIMEOUT_CYCLES idle cycles have elapsed without a clear.
module loader_timeout
  import loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int                CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;

  // Idle-cycle counter; saturates at LIMIT so expired cannot re-arm on wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clear || !enable) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_r != LIMIT) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // A byte arriving in the firing cycle suppresses the timeout.
  assign expired = enable && !clear && (cnt_r == LIMIT);

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader: MAGIC, 16-bit count, little-endian words -> IMEM writes.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module program_loader
  import loader_pkg::*;
#(
  parameter int          Nloc           = 32,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [7:0]  MAGIC          = MAGIC_DEFAULT,
  parameter int          TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        wr_enable,
  output logic [31:0] wr_address,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        busy,
  output logic        load_done,
  output logic        load_error
);

  localparam int          IDX_W    = $clog2(Nloc) + 1;
  localparam logic [15:0] NLOC_CNT = 16'(Nloc);

  state_t                          state_r;
  state_t                          state_next_s;
  logic [15:0]                     count_r;
  logic [IDX_W-1:0]                index_r;
  logic [1:0]                      lane_r;
  logic [WORD_W-BYTE_W-1:0]        shift_r;
  logic                            wr_enable_r;
  logic [WORD_W-1:0]               wr_address_r;
  logic [WORD_W-1:0]               wr_data_r;
  logic                            cpu_hold_r;
  logic                            busy_r;
  logic                            load_done_r;
  logic                            load_error_r;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]               sum_r;
`endif

  logic        start_s;
  logic        cnt_lo_s;
  logic        cnt_hi_s;
  logic        data_s;
  logic        write_s;
  logic        done_s;
  logic        error_s;
  logic        expired_s;
  logic [15:0] count_full_s;
  logic        last_word_s;

  assign count_full_s = {rx_data, count_r[7:0]};
  assign last_word_s  = (({{(16-IDX_W){1'b0}}, index_r} + 16'd1) == count_r);

  loader_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (rx_valid),
    .enable  (state_r != ST_IDLE),
    .expired (expired_s)
  );

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and per-edge control strobes; an accepted byte always beats the timeout.
  always_comb begin
    state_next_s = state_r;
    start_s      = 1'b0;
    cnt_lo_s     = 1'b0;
    cnt_hi_s     = 1'b0;
    data_s       = 1'b0;
    write_s      = 1'b0;
    done_s       = 1'b0;
    error_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rx_valid && (rx_data == MAGIC)) begin
          start_s      = 1'b1;
          state_next_s = ST_CNT_LO;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CNT_LO: begin
        if (rx_valid) begin
          cnt_lo_s     = 1'b1;
          state_next_s = ST_CNT_HI;
        end else if (expired_s) begin
          error_s      = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_CNT_LO;
        end
      end
      ST_CNT_HI: begin
        if (rx_valid) begin
          cnt_hi_s = 1'b1;
          if (count_full_s > NLOC_CNT) begin
            error_s      = 1'b1;
            state_next_s = ST_IDLE;
          end else if (count_full_s == 16'd0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state_next_s = ST_CSUM;
`else
            done_s       = 1'b1;
            state_next_s = ST_IDLE;
`endif
          end else begin
            state_next_s = ST_DATA;
          end
        end else if (expired_s) begin
          error_s      = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_CNT_HI;
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          data_s = 1'b1;
          if (lane_r == 2'd3) begin
            write_s = 1'b1;
            if (last_word_s) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              state_next_s = ST_CSUM;
`else
              done_s       = 1'b1;
              state_next_s = ST_IDLE;
`endif
            end else begin
              state_next_s = ST_DATA;
            end
          end else begin
            state_next_s = ST_DATA;
          end
        end else if (expired_s) begin
          error_s      = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DATA;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (rx_valid) begin
          if (rx_data == sum_r) begin
            done_s = 1'b1;
          end else begin
            error_s = 1'b1;
          end
          state_next_s = ST_IDLE;
        end else if (expired_s) begin
          error_s      = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_CSUM;
        end
      end
`endif
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Status flags; cpu_hold is released only by a successful frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cpu_hold_r   <= 1'b0;
      load_done_r  <= 1'b0;
      load_error_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      busy_r <= (state_next_s != ST_IDLE);
      if (start_s) begin
        cpu_hold_r   <= 1'b1;
        load_done_r  <= 1'b0;
        load_error_r <= 1'b0;
      end else if (done_s) begin
        cpu_hold_r   <= 1'b0;
        load_done_r  <= 1'b1;
      end else if (error_s) begin
        load_error_r <= 1'b1;
      end else begin
        cpu_hold_r   <= cpu_hold_r;
        load_done_r  <= load_done_r;
        load_error_r <= load_error_r;
      end
    end
  end

  // Frame counters and byte assembly; lane 3 completes the word and issues the write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_r      <= 16'd0;
      index_r      <= {IDX_W{1'b0}};
      lane_r       <= 2'd0;
      shift_r      <= {(WORD_W-BYTE_W){1'b0}};
      wr_enable_r  <= 1'b0;
      wr_address_r <= 32'd0;
      wr_data_r    <= 32'd0;
    end else begin
      wr_enable_r <= write_s;
      if (start_s) begin
        index_r <= {IDX_W{1'b0}};
        lane_r  <= 2'd0;
      end else if (data_s) begin
        lane_r  <= lane_r + 2'd1;
        shift_r <= {rx_data, shift_r[WORD_W-BYTE_W-1:BYTE_W]};
      end else begin
        lane_r  <= lane_r;
      end
      if (cnt_lo_s) begin
        count_r[7:0] <= rx_data;
      end else if (cnt_hi_s) begin
        count_r[15:8] <= rx_data;
      end else begin
        count_r <= count_r;
      end
      if (write_s) begin
        wr_data_r    <= {rx_data, shift_r};
        wr_address_r <= BASE_ADDR + {{(30-IDX_W){1'b0}}, index_r, 2'b00};
        index_r      <= index_r + {{(IDX_W-1){1'b0}}, 1'b1};
      end else begin
        wr_data_r    <= wr_data_r;
        wr_address_r <= wr_address_r;
      end
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  // Running mod-256 sum of DATA bytes, compared against the trailing byte in CSUM.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sum_r <= 8'd0;
    end else if (start_s) begin
      sum_r <= 8'd0;
    end else if (data_s) begin
      sum_r <= sum_r + rx_data;
    end else begin
      sum_r <= sum_r;
    end
  end
`endif

  assign wr_enable  = wr_enable_r;
  assign wr_address = wr_address_r;
  assign wr_data    = wr_data_r;
  assign cpu_hold   = cpu_hold_r;
  assign busy       = busy_r;
  assign load_done  = load_done_r;
  assign load_error = load_error_r;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: random frames against a byte-level frame model.
// Honours PROGRAM_LOADER_CHECKSUM_EN by appending the checksum byte.
module tb_program_loader;

  localparam int          NLOC  = 32;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [7:0]  MAGIC = 8'hA5;
  localparam int          TMO   = 40;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        wr_enable;
  logic [31:0] wr_address;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        busy;
  logic        load_done;
  logic        load_error;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_q[$];
  logic [31:0] fixed_w[$];
  int          fixed_gap = -1;
  logic        prev_we = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic        corrupt_csum = 1'b0;
`endif

  always #5 clock = ~clock;

  program_loader #(
    .Nloc           (NLOC),
    .BASE_ADDR      (BASE),
    .MAGIC          (MAGIC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .wr_enable  (wr_enable),
    .wr_address (wr_address),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .load_done  (load_done),
    .load_error (load_error)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: every write strobe is matched against the head of the expected queue.
  always @(negedge clock) begin
    if (reset_n && wr_enable) begin
      check("wr_enable_width", {31'd0, prev_we}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_write", {31'd0, wr_enable}, 32'd0);
      end else begin
        check("wr_address", wr_address, exp_q[0][63:32]);
        check("wr_data", wr_data, exp_q[0][31:0]);
        void'(exp_q.pop_front());
      end
    end
    prev_we <= reset_n & wr_enable;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (gap) @(posedge clock);
    #1;
  endtask

  task automatic check_status(input string tag, input logic done, input logic err, input logic hold);
    check({tag, "_load_done"}, {31'd0, load_done}, {31'd0, done});
    check({tag, "_load_error"}, {31'd0, load_error}, {31'd0, err});
    check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, hold});
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_pending_writes"}, exp_q.size(), 32'd0);
  endtask

  // Reference model: build the frame bytes and expected writes from the frame rules.
  task automatic run_frame(input string tag, input int count, input int gapmax, input bit stray);
    logic [7:0]  bytes[$];
    logic [15:0] c16;
    logic [31:0] w;
    bit          ok;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]  sum = 8'h00;
`endif
    c16 = 16'(count);
    if (stray) begin
      bytes.push_back(8'h00);
      bytes.push_back(8'hFF);
      bytes.push_back(8'h5A);
    end
    bytes.push_back(MAGIC);
    bytes.push_back(c16[7:0]);
    bytes.push_back(c16[15:8]);
    ok = (count <= NLOC);
    if (ok) begin
      for (int i = 0; i < count; i++) begin
        if (fixed_w.size() != 0) w = fixed_w.pop_front();
        else w = $urandom;
        for (int k = 0; k < 4; k++) begin
          bytes.push_back(w[8*k +: 8]);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          sum = sum + w[8*k +: 8];
`endif
        end
        exp_q.push_back({BASE + 32'(4 * i), w});
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      bytes.push_back(corrupt_csum ? sum + 8'd1 : sum);
      if (corrupt_csum) ok = 1'b0;
`endif
    end
    foreach (bytes[i]) begin
      send_byte(bytes[i], (fixed_gap >= 0) ? fixed_gap : int'($urandom_range(0, gapmax)));
    end
    repeat (3) @(posedge clock);
    #1;
    if (ok) check_status(tag, 1'b1, 1'b0, 1'b0);
    else check_status(tag, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check("reset_wr_enable", {31'd0, wr_enable}, 32'd0);
    check("reset_wr_address", wr_address, 32'd0);
    check("reset_wr_data", wr_data, 32'd0);
    check_status("reset", 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    fixed_w.push_back(32'h1234_5678);
    fixed_w.push_back(32'hDEAD_BEEF);
    run_frame("frame_a", 2, 2, 1'b0);

    run_frame("count_over", 33, 2, 1'b0);
    run_frame("count_zero", 0, 2, 1'b0);
    run_frame("count_ffff", 16'hFFFF, 1, 1'b0);
    run_frame("count_max", NLOC, 1, 1'b0);

    // Timeout in the middle of a word: nothing written, error sticky, hold kept.
    send_byte(MAGIC, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    repeat (TMO + 5) @(posedge clock);
    #1;
    check_status("timeout", 1'b0, 1'b1, 1'b1);
    run_frame("after_timeout", 2, 3, 1'b0);

    fixed_gap = TMO - 1;
    run_frame("gap_edge", 1, 0, 1'b0);
    fixed_gap = -1;

    run_frame("stray_b2b", 5, 0, 1'b1);

    // Reset after the second data byte: aborted frame must never write.
    send_byte(MAGIC, 0);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    reset_n = 1'b0;
    @(negedge clock);
    check("midreset_wr_address", wr_address, 32'd0);
    check("midreset_wr_data", wr_data, 32'd0);
    check_status("midreset", 1'b0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    run_frame("after_reset", 2, 2, 1'b0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    fixed_w.push_back(32'h0403_0201);
    run_frame("csum_good", 1, 1, 1'b0);
    corrupt_csum = 1'b1;
    fixed_w.push_back(32'h0403_0201);
    run_frame("csum_bad", 1, 1, 1'b0);
    corrupt_csum = 1'b0;
`endif

    for (int n = 0; n < 8; n++) begin
      run_frame("random", int'($urandom_range(0, NLOC + 2)), 3, n[0]);
    end

    check("final_pending_writes", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream program writer that fills the instruction memory's write port (wr_enable / wr_address / wr_data) while holding the CPU in reset.
- Sits between the UART receiver (single-cycle byte strobes, no backpressure) and the instruction memory.
- Parses a framed load:
  - magic byte
  - 16-bit word count
  - little-endian 32-bit words
  - optional checksum
- Issues one memory write per completed word.

Parameters:
- Nloc, 32: instruction memory depth in words; maximum accepted word count.
- BASE_ADDR, 32'h0000_0000: byte address of the first word written.
- MAGIC, 8'hA5: frame start byte.
- TIMEOUT_CYCLES, 1250000: idle cycles allowed between bytes inside a frame (100 ms at 12.5 MHz).

Ports:
- clock, input, 1: system clock (12.5 MHz).
- reset_n, input, 1: asynchronous active-low reset.
- rx_data, input, 8: received byte.
- rx_valid, input, 1: one-cycle strobe; rx_data is valid this cycle.
- wr_enable, output, 1: one-cycle memory write strobe.
- wr_address, output, 32: byte address of the write; word aligned.
- wr_data, output, 32: assembled word.
- cpu_hold, output, 1: holds the CPU in reset while loading.
- busy, output, 1: high when the FSM is not in IDLE.
- load_done, output, 1: sticky; last frame completed OK.
- load_error, output, 1: sticky; last frame aborted.

Behaviour:
- Reset: one clock domain; reset is asynchronous, active-low (reset_n). While reset_n is low, all outputs and registers read 0 and the FSM is in IDLE. Reset mid-frame abandons the frame with no further writes.
- States: IDLE, CNT_LO, CNT_HI, DATA, CSUM (CSUM exists only with the optional feature).
- IDLE:
  - rx_valid with rx_data==MAGIC -> CNT_LO.
  - On that same edge: cpu_hold<=1, load_done<=0, load_error<=0, word index<=0, byte lane<=0, checksum<=0.
  - Any other byte is ignored.
- CNT_LO: on a byte, latch count[7:0] -> CNT_HI.
- CNT_HI: on a byte, latch count[15:8], then evaluate the full count:
  - count > Nloc: -> IDLE, load_error<=1, cpu_hold stays 1.
  - count == 0: -> IDLE, load_done<=1, cpu_hold<=0. With the optional feature enabled, count == 0 instead goes to CSUM.
  - otherwise -> DATA.
- DATA:
  - Bytes fill the shift register little-endian: lane 0 -> [7:0], lane 3 -> [31:24].
  - When a lane-3 byte is accepted, on the next edge: wr_enable=1 for exactly one cycle, wr_data=assembled word, wr_address=BASE_ADDR + 4*index. Write latency is 1 cycle after the 4th byte's strobe.
  - wr_address and wr_data hold their values until the next write; wr_enable returns to 0.
  - After the last word: -> IDLE with load_done<=1 and cpu_hold<=0 on the same edge as the final wr_enable. With the optional feature enabled, go to CSUM instead.
  - Index width: $clog2(Nloc)+1 bits. It never wraps, because count <= Nloc.
- Timeout:
  - A counter of cycles since the last accepted byte runs in every non-IDLE state and clears on rx_valid.
  - When it reaches TIMEOUT_CYCLES: -> IDLE, load_error<=1, cpu_hold stays 1, and the partial word is discarded (not written).
  - If rx_valid occurs in the same cycle the timeout would fire, the byte wins and the timeout does not fire.
- cpu_hold after an error: stays 1 until a later frame completes successfully, because the memory contents are suspect.
- Back-to-back strobes (rx_valid on consecutive cycles): fully supported, no byte lost.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum, mod 256, of all DATA bytes is kept.
  - After the last word (or immediately after CNT_HI when count==0), CSUM waits for one byte.
  - Byte matches the sum: load_done<=1, cpu_hold<=0.
  - Mismatch: load_error<=1, cpu_hold stays 1.
  - Either way -> IDLE. Words are already written regardless of the outcome.
  - Timeout applies in CSUM.
- Undefined: no CSUM state and no checksum byte. The frame ends at the last word.

Decomposition:
- Package loader_pkg:
  - state enum typedef
  - MAGIC default
  - TIMEOUT_CYCLES default
  - word/byte width constants
- One natural sub-module: loader_timeout. It holds the inter-byte counter, with inputs clear/enable and a one-cycle expired output.

Test Plan:
- Frame A5 02 00 | 78 56 34 12 | EF BE AD DE -> writes (0x0, 0x12345678) then (0x4, 0xDEADBEEF), each wr_enable 1 cycle; load_done=1, cpu_hold=0.
- Count 0x0021 with Nloc=32 -> no writes; load_error=1, cpu_hold=1, busy=0 after the count byte.
- A5 01 00 11 22 followed by silence for TIMEOUT_CYCLES -> no write; load_error=1; a following valid frame clears load_error and sets load_done.
- Stray bytes 00 FF 5A before A5, and every frame byte strobed on consecutive cycles -> stray bytes ignored, all words written correctly.
- reset_n pulled low after the 2nd data byte, then a full frame sent -> no write from the aborted frame; the new frame writes from BASE_ADDR.
- With PROGRAM_LOADER_CHECKSUM_EN, frame A5 01 00 01 02 03 04 then checksum 0A -> load_done=1. Checksum 0B -> load_error=1, the word 0x04030201 is still written.
